led_blinker: RTL and testbench

- Multi-channel, software-configurable LED driver. Generalises the single fixed-rate LED toggler to NUM_LEDS independent channels.
- One shared tick prescaler drives all channels.
- Each channel has a mode: off, on, continuous blink with programmable half-period, or a counted burst with a completion pulse.
- Sits on board top level, driven by a simple register-write strobe from the control logic.

---
 rtl/led_blinker.sv | 132 +++++++++++++
 tb/tb_led_blinker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/led_blinker.sv
// led_blinker - multi-channel LED driver with shared tick prescaler, blink and counted-burst modes.
// Optional LED_ACTIVE_LOW_EN inverts the led output (reset drives all ones).
module led_blinker #(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 50000,
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [CNT_W-1:0]    wr_count,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] busy,
  output logic [NUM_LEDS-1:0] done
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  logic [PS_W-1:0]     ps_q, ps_d;
  logic                tick;
  mode_e               mode_q   [NUM_LEDS];
  mode_e               mode_d   [NUM_LEDS];
  logic [PERIOD_W-1:0] period_q [NUM_LEDS];
  logic [PERIOD_W-1:0] period_d [NUM_LEDS];
  logic [PERIOD_W-1:0] ph_q     [NUM_LEDS];
  logic [PERIOD_W-1:0] ph_d     [NUM_LEDS];
  logic [CNT_W-1:0]    rem_q    [NUM_LEDS];
  logic [CNT_W-1:0]    rem_d    [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] busy_q, busy_d;
  logic [NUM_LEDS-1:0] done_q, done_d;
  logic                wr_valid;

  assign tick     = (ps_q == PS_MAX);
  assign wr_valid = wr_en && (32'(wr_ch) < NUM_LEDS);

  always_comb begin
    ps_d = tick ? '0 : ps_q + 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      ph_d[i]     = ph_q[i];
      rem_d[i]    = rem_q[i];
      led_d[i]    = led_q[i];
      done_d[i]   = 1'b0;
      // A write to this channel takes priority over a coincident tick.
      if (wr_valid && (wr_ch == CH_W'(i))) begin
        mode_d[i]   = mode_e'(wr_mode);
        period_d[i] = (wr_period == '0) ? PERIOD_W'(1) : wr_period;
        ph_d[i]     = '0;
        rem_d[i]    = wr_count;
        case (mode_e'(wr_mode))
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = 1'b1;
          MODE_BURST: begin
            if (wr_count == '0) begin
              mode_d[i] = MODE_OFF;
              led_d[i]  = 1'b0;
              done_d[i] = 1'b1;
            end else begin
              led_d[i]  = 1'b1;
            end
          end
          default:    led_d[i] = 1'b0;
        endcase
      end else if (tick && (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BURST)) begin
        if (ph_q[i] == period_q[i] - PERIOD_W'(1)) begin
          ph_d[i]  = '0;
          led_d[i] = ~led_q[i];
          // Bursts count falling edges; the last one ends the burst.
          if (mode_q[i] == MODE_BURST && led_q[i]) begin
            rem_d[i] = rem_q[i] - CNT_W'(1);
            if (rem_q[i] == CNT_W'(1)) begin
              mode_d[i] = MODE_OFF;
              done_d[i] = 1'b1;
            end
          end
        end else begin
          ph_d[i] = ph_q[i] + PERIOD_W'(1);
        end
      end
      busy_d[i] = (mode_d[i] == MODE_BURST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q   <= '0;
      led_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        ph_q[i]     <= '0;
        rem_q[i]    <= '0;
      end
    end else begin
      ps_q     <= ps_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      ph_q     <= ph_d;
      rem_q    <= rem_d;
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~led_q;
`else
  assign led = led_q;
`endif
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_blinker.sv
// tb/tb_led_blinker.sv - directed self-checking bench for led_blinker.
module tb_led_blinker;

  localparam int NUM  = 3;
  localparam int TDIV = 4;
  localparam int PW   = 8;
  localparam int CW   = 8;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [NUM-1:0] LED_XOR = '1;
`else
  localparam logic [NUM-1:0] LED_XOR = '0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [1:0]     wr_mode = '0;
  logic [PW-1:0]  wr_period = '0;
  logic [CW-1:0]  wr_count = '0;
  logic [NUM-1:0] led, busy, done;
  logic [NUM-1:0] led_n;
  int             n_tests = 0;
  int             n_fail = 0;
  int             edges = 0;

  led_blinker #(
    .NUM_LEDS(NUM), .TICK_DIV(TDIV), .PERIOD_W(PW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_period(wr_period), .wr_count(wr_count), .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign led_n = led ^ LED_XOR;

  // Posedges since reset release; equals the prescaler count modulo TDIV.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] ch, input logic [1:0] mode,
                       input logic [PW-1:0] per, input logic [CW-1:0] cnt);
    wr_en = 1'b1; wr_ch = ch; wr_mode = mode; wr_period = per; wr_count = cnt;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Park on a negedge whose following posedge carries a tick.
  task automatic align();
    int guard = 0;
    while ((edges % TDIV) != TDIV - 1 && guard < 2 * TDIV) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic e_led, e_busy, e_done;
    #2 rst = 1'b1;
    #1 check("reset_async", {led_n, busy, done}, '0);
    cycles(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle", {led_n, busy, done}, '0);
    end

    drive(0, 2'd1, 0, 0);
    check("on_ch0", {led_n, busy, done}, {3'b001, 3'b000, 3'b000});
    drive(2'd3, 2'd1, 5, 5);
    check("bad_ch", {led_n, busy, done}, {3'b001, 3'b000, 3'b000});
    drive(0, 2'd0, 0, 0);
    check("off_ch0", {led_n, busy, done}, '0);

    align();
    drive(1, 2'd2, 2, 0);
    for (int j = 0; j < 32; j++) begin
      e_led = ((j / 8) % 2) == 0;
      check("blink_ch1", {led_n, busy}, {1'b0, e_led, 1'b0, 3'b000});
      @(negedge clk);
    end
    drive(1, 2'd0, 0, 0);
    check("blink_off", led_n, 3'b000);

    align();
    drive(2, 2'd3, 1, 3);
    for (int j = 0; j < 28; j++) begin
      e_led  = (j < 20) && (((j / 4) % 2) == 0);
      e_busy = (j < 20);
      e_done = (j == 20);
      check("burst_ch2", {led_n[2], busy[2], done[2]}, {e_led, e_busy, e_done});
      @(negedge clk);
    end

    align();
    drive(0, 2'd2, 0, 0);
    for (int j = 0; j < 12; j++) begin
      e_led = ((j / 4) % 2) == 0;
      check("blink_per0", led_n[0], e_led);
      @(negedge clk);
    end
    drive(0, 2'd0, 0, 0);

    drive(0, 2'd3, 1, 0);
    check("burst_cnt0", {led_n[0], busy[0], done[0]}, 3'b001);
    @(negedge clk);
    check("burst_cnt0_after", {led_n[0], busy[0], done[0]}, 3'b000);

    align();
    drive(2, 2'd3, 1, 5);
    cycles(5);
    check("mid_burst", {led_n[2], busy[2], done[2]}, 3'b010);
    drive(2, 2'd1, 0, 0);
    check("overwrite_on", {led_n[2], busy[2], done[2]}, 3'b100);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      check("overwrite_hold", {led_n[2], busy, done}, {1'b1, 6'b0});
    end
    drive(2, 2'd0, 0, 0);

    align();
    drive(0, 2'd3, 1, 1);
    drive(1, 2'd3, 1, 1);
    cycles(2);
    check("simul_pre", {led_n, busy, done}, {3'b011, 3'b011, 3'b000});
    cycles(1);
    check("simul_done", {led_n, busy, done}, {3'b000, 3'b000, 3'b011});
    cycles(1);
    check("simul_post", {led_n, busy, done}, '0);

    align();
    drive(1, 2'd2, 2, 0);
    drive(2, 2'd3, 4, 9);
    cycles(3);
    check("pre_reset", {led_n, busy}, {3'b110, 3'b100});
    #2 rst = 1'b1;
    #1 check("reset_mid", {led_n, busy, done}, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("post_reset", {led_n, busy, done}, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
